// File: rtl/display_scan.sv
// rtl/display_scan.sv - six-digit HH:MM:SS time-multiplexed scan driver
module display_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [23:0] digits,
    input  logic        blank_lz,
    input  logic        colon,
    output logic [3:0]  num,
    output logic [5:0]  an_n,
    output logic        dp_n,
    output logic [2:0]  slot
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] GUARD_V  = PW'(GUARD);

    logic [PW-1:0] pre;
    logic [2:0]    slot_q;
    logic [23:0]   snap_digits;
    logic          snap_en;
    logic          snap_blz;
    logic          snap_colon;
    logic          load_pend;

    logic          wrap;
    logic          frame_end;
    logic [3:0]    cur;
    logic          visible;

    assign wrap      = (pre == PRE_LAST);
    assign frame_end = wrap && (slot_q == 3'd5);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre         <= '0;
            slot_q      <= 3'd0;
            snap_digits <= 24'h0;
            snap_en     <= 1'b0;
            snap_blz    <= 1'b0;
            snap_colon  <= 1'b0;
            load_pend   <= 1'b1;
        end else begin
            pre <= wrap ? '0 : pre + 1'b1;
            if (wrap)
                slot_q <= (slot_q == 3'd5) ? 3'd0 : slot_q + 3'd1;
            // Sampling only at the frame boundary keeps each frame coherent.
            if (frame_end || load_pend) begin
                snap_digits <= digits;
                snap_en     <= en;
                snap_blz    <= blank_lz;
                snap_colon  <= colon;
            end
            load_pend <= 1'b0;
        end
    end

    always_comb begin
        cur = 4'h0;
        case (slot_q)
            3'd0:    cur = snap_digits[3:0];
            3'd1:    cur = snap_digits[7:4];
            3'd2:    cur = snap_digits[11:8];
            3'd3:    cur = snap_digits[15:12];
            3'd4:    cur = snap_digits[19:16];
            3'd5:    cur = snap_digits[23:20];
            default: cur = 4'h0;
        endcase
    end

    always_comb begin
        visible = snap_en && (pre >= GUARD_V) && (cur <= 4'd9)
                  && !((slot_q == 3'd5) && snap_blz && (cur == 4'd0));
        num  = (cur > 4'd9) ? 4'hF : cur;
        an_n = visible ? ~(6'b000001 << slot_q) : 6'b111111;
        dp_n = !(visible && snap_colon && ((slot_q == 3'd2) || (slot_q == 3'd4)));
    end

    assign slot = slot_q;

endmodule

// File: tb/tb_display_scan.sv
// tb/tb_display_scan.sv - scoreboard bench for display_scan with a frame-level reference model
module tb_display_scan;

    localparam int DIV   = 8;
    localparam int GRD   = 2;
    localparam int FRAME = 6 * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [23:0] digits = 24'h0;
    logic        blank_lz = 1'b0;
    logic        colon = 1'b0;
    logic [3:0]  num;
    logic [5:0]  an_n;
    logic        dp_n;
    logic [2:0]  slot;

    display_scan #(.SCAN_DIV(DIV), .GUARD(GRD)) dut (
        .clk(clk), .rst(rst), .en(en), .digits(digits), .blank_lz(blank_lz),
        .colon(colon), .num(num), .an_n(an_n), .dp_n(dp_n), .slot(slot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] num;
        logic [5:0] an;
        logic       dp;
        logic [2:0] slot;
    } exp_t;

    exp_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;
    bit   started = 0;

    // Model: n counts non-reset edges since the last reset; the snapshot is a
    // copy of the inputs taken on the first edge and at every frame boundary.
    int         n = 0;
    logic [3:0] m_dig[6];
    bit         m_en, m_blz, m_colon;

    function automatic exp_t predict();
        exp_t e;
        int   p, s;
        int   d;
        bit   vis;
        p   = n % DIV;
        s   = (n / DIV) % 6;
        d   = int'(m_dig[s]);
        vis = m_en && (p >= GRD) && (d <= 9) && !(s == 5 && m_blz && d == 0);
        e.num  = (d > 9) ? 4'hF : 4'(d);
        e.an   = vis ? ~(6'b000001 << s) : 6'b111111;
        e.dp   = !(vis && m_colon && (s == 2 || s == 4));
        e.slot = 3'(s);
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            started = 1;
            n = 0;
            for (int i = 0; i < 6; i++) m_dig[i] = 4'h0;
            m_en = 0; m_blz = 0; m_colon = 0;
        end else if (started) begin
            if (n == 0 || (n + 1) % FRAME == 0) begin
                for (int i = 0; i < 6; i++) m_dig[i] = digits[4*i +: 4];
                m_en = en; m_blz = blank_lz; m_colon = colon;
            end
            n = n + 1;
        end
        if (started) exp_q.push_back(predict());
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            compared++;
            if (num !== e.num || an_n !== e.an || dp_n !== e.dp || slot !== e.slot) begin
                mismatched++;
                $display("FAIL scan_out t=%0t: got num=%h an_n=%b dp_n=%b slot=%0d, required num=%h an_n=%b dp_n=%b slot=%0d",
                         $time, num, an_n, dp_n, slot, e.num, e.an, e.dp, e.slot);
            end
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input int ph);
        int guard_cnt;
        guard_cnt = 0;
        while ((n % FRAME) != ph && guard_cnt < 4 * FRAME) begin
            cyc(1);
            guard_cnt++;
        end
        if ((n % FRAME) != ph) begin
            mismatched++;
            $display("FAIL wait_phase: got phase %0d, required %0d", n % FRAME, ph);
        end
    endtask

    initial begin
        // reset release
        rst = 1; en = 1; digits = 24'h123456; blank_lz = 0; colon = 0;
        cyc(3);
        rst = 0;
        cyc(2 * FRAME);

        // tear-free update at slot 3
        digits = 24'h235959;
        wait_phase(0);
        cyc(FRAME);
        wait_phase(3 * DIV);
        digits = 24'h000000;
        cyc(2 * FRAME);

        // leading-zero blank, then without
        digits = 24'h091500; blank_lz = 1;
        cyc(2 * FRAME);
        blank_lz = 0;
        cyc(2 * FRAME);

        // colon
        colon = 1; digits = 24'h124530;
        cyc(2 * FRAME);
        colon = 0;

        // invalid BCD in digit 1
        digits = 24'h1234C6;
        cyc(2 * FRAME);

        // en falling mid-frame
        digits = 24'h101010;
        wait_phase(2 * DIV + 3);
        en = 0;
        cyc(2 * FRAME);
        en = 1;

        // mid-frame reset at slot 3, pre 5
        digits = 24'h987654;
        wait_phase(3 * DIV + 5);
        rst = 1;
        cyc(1);
        rst = 0;
        digits = 24'h050403;
        cyc(2 * FRAME);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) digits = $urandom();
            if ($urandom_range(0, 9) == 0) en = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0) blank_lz = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0) colon = $urandom_range(0, 1);
            rst = ($urandom_range(0, 199) == 0);
            cyc(1);
        end
        rst = 0;
        cyc(FRAME);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
